// File: rtl/pipe_decode_stage.sv
// Y86-64 pipelined decode stage: F->D register, register-ID decode, operand select and hazard control.
// Define PIPE_DECODE_FWD_EN for the E/M/W forwarding network; otherwise any pending writer stalls decode.
module pipe_decode_stage #(
   parameter int                DATA_W = 64,
   parameter int                RID_W  = 4,
   parameter logic [RID_W-1:0]  RSP_ID = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_valid,
   input  logic [3:0]        f_icode,
   input  logic [3:0]        f_ifun,
   input  logic [RID_W-1:0]  f_rA,
   input  logic [RID_W-1:0]  f_rB,
   input  logic [DATA_W-1:0] f_valC,
   input  logic [DATA_W-1:0] f_valP,
   input  logic              ext_stall,
   input  logic              e_mispredict,
   input  logic [3:0]        e_icode,
   input  logic [RID_W-1:0]  e_dstE,
   input  logic [RID_W-1:0]  e_dstM,
   input  logic [DATA_W-1:0] e_valE,
   input  logic [RID_W-1:0]  m_dstE,
   input  logic [DATA_W-1:0] m_valE,
   input  logic [RID_W-1:0]  m_dstM,
   input  logic [DATA_W-1:0] m_valM,
   input  logic [RID_W-1:0]  w_dstE,
   input  logic [DATA_W-1:0] w_valE,
   input  logic [RID_W-1:0]  w_dstM,
   input  logic [DATA_W-1:0] w_valM,
   output logic [RID_W-1:0]  rf_srcA,
   output logic [RID_W-1:0]  rf_srcB,
   input  logic [DATA_W-1:0] rf_valA,
   input  logic [DATA_W-1:0] rf_valB,
   output logic              d_valid,
   output logic [3:0]        d_icode,
   output logic [3:0]        d_ifun,
   output logic [DATA_W-1:0] d_valC,
   output logic [DATA_W-1:0] d_valA,
   output logic [DATA_W-1:0] d_valB,
   output logic [RID_W-1:0]  d_srcA,
   output logic [RID_W-1:0]  d_srcB,
   output logic [RID_W-1:0]  d_dstE,
   output logic [RID_W-1:0]  d_dstM,
   output logic              f_stall,
   output logic              e_bubble
);

   localparam logic [RID_W-1:0] RNONE  = '1;
   localparam logic [3:0]       I_NOP  = 4'd1;
   localparam logic [3:0]       I_JXX  = 4'd7;
   localparam logic [3:0]       I_CALL = 4'd8;
   localparam logic [3:0]       I_MRMV = 4'd5;
   localparam logic [3:0]       I_POP  = 4'd11;

   logic              vld_p0;
   logic [3:0]        icode_p0;
   logic [3:0]        ifun_p0;
   logic [RID_W-1:0]  ra_p0;
   logic [RID_W-1:0]  rb_p0;
   logic [DATA_W-1:0] valc_p0;
   logic [DATA_W-1:0] valp_p0;

   logic [RID_W-1:0]  srca, srcb, dste, dstm;
   logic [DATA_W-1:0] opa, opb;
   logic              hazard;
   logic              hold;

   function automatic logic hit(input logic [RID_W-1:0] src, input logic [RID_W-1:0] dst);
      return (src != RNONE) && (src == dst);
   endfunction

   // ---- F -> D register (p0) ----
   always_ff @(posedge clk) begin
      if (!rst_n || e_mispredict) begin
         vld_p0   <= 1'b0;
         icode_p0 <= I_NOP;
         ifun_p0  <= 4'd0;
         ra_p0    <= RNONE;
         rb_p0    <= RNONE;
         valc_p0  <= '0;
         valp_p0  <= '0;
      end else if (!hold) begin
         vld_p0   <= f_valid;
         icode_p0 <= f_icode;
         ifun_p0  <= f_ifun;
         ra_p0    <= f_rA;
         rb_p0    <= f_rB;
         valc_p0  <= f_valC;
         valp_p0  <= f_valP;
      end
   end

   // ---- decode (combinational from p0) ----
   always_comb begin
      srca = RNONE;
      srcb = RNONE;
      dste = RNONE;
      dstm = RNONE;
      case (icode_p0)
         4'd2:  begin srca = ra_p0;  dste = rb_p0; end
         4'd3:  dste = rb_p0;
         4'd4:  begin srca = ra_p0;  srcb = rb_p0; end
         4'd5:  begin srcb = rb_p0;  dstm = ra_p0; end
         4'd6:  begin srca = ra_p0;  srcb = rb_p0;  dste = rb_p0; end
         4'd8:  begin srcb = RSP_ID; dste = RSP_ID; end
         4'd9:  begin srca = RSP_ID; srcb = RSP_ID; dste = RSP_ID; end
         4'd10: begin srca = ra_p0;  srcb = RSP_ID; dste = RSP_ID; end
         4'd11: begin srca = RSP_ID; srcb = RSP_ID; dste = RSP_ID; dstm = ra_p0; end
         default: ;
      endcase
   end

`ifdef PIPE_DECODE_FWD_EN
   // Youngest producer wins; memory results beat ALU results within the M stage.
   function automatic logic [DATA_W-1:0] fwd(input logic [RID_W-1:0] src,
                                             input logic [DATA_W-1:0] rfval);
      if (hit(src, e_dstE))      return e_valE;
      else if (hit(src, m_dstM)) return m_valM;
      else if (hit(src, m_dstE)) return m_valE;
      else if (hit(src, w_dstM)) return w_valM;
      else if (hit(src, w_dstE)) return w_valE;
      return rfval;
   endfunction

   always_comb begin
      opa    = fwd(srca, rf_valA);
      opb    = fwd(srcb, rf_valB);
      hazard = vld_p0 && (e_icode == I_MRMV || e_icode == I_POP) &&
               (hit(srca, e_dstM) || hit(srcb, e_dstM));
   end
`else
   function automatic logic pending(input logic [RID_W-1:0] src);
      return hit(src, e_dstE) || hit(src, e_dstM) || hit(src, m_dstE) ||
             hit(src, m_dstM) || hit(src, w_dstE) || hit(src, w_dstM);
   endfunction

   logic unused_fwd;
   assign unused_fwd = ^{e_icode, e_valE, m_valE, m_valM, w_valE, w_valM};

   always_comb begin
      opa    = rf_valA;
      opb    = rf_valB;
      hazard = vld_p0 && (pending(srca) || pending(srcb));
   end
`endif

   assign hold     = ext_stall || hazard;
   assign f_stall  = hold;
   assign e_bubble = hazard || e_mispredict;

   assign rf_srcA  = srca;
   assign rf_srcB  = srcb;

   // ---- D -> E outputs, cleared when the slot is empty ----
   assign d_valid  = vld_p0;
   assign d_icode  = vld_p0 ? icode_p0 : 4'd0;
   assign d_ifun   = vld_p0 ? ifun_p0  : 4'd0;
   assign d_valC   = vld_p0 ? valc_p0  : '0;
   assign d_valA   = !vld_p0 ? '0 :
                     (icode_p0 == I_JXX || icode_p0 == I_CALL) ? valp_p0 : opa;
   assign d_valB   = vld_p0 ? opb  : '0;
   assign d_srcA   = vld_p0 ? srca : RNONE;
   assign d_srcB   = vld_p0 ? srcb : RNONE;
   assign d_dstE   = vld_p0 ? dste : RNONE;
   assign d_dstM   = vld_p0 ? dstm : RNONE;

endmodule

// File: tb/tb_pipe_decode_stage.sv
// Directed bench for pipe_decode_stage with a per-cycle reference model and literal spot checks.
module tb_pipe_decode_stage;

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RSP   = 4'h4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        f_valid = 1'b0;
   logic [3:0]  f_icode = 4'd1, f_ifun = 4'd0, f_rA = RNONE, f_rB = RNONE;
   logic [63:0] f_valC = '0, f_valP = '0;
   logic        ext_stall = 1'b0, e_mispredict = 1'b0;
   logic [3:0]  e_icode = 4'd1, e_dstE = RNONE, e_dstM = RNONE;
   logic [3:0]  m_dstE = RNONE, m_dstM = RNONE, w_dstE = RNONE, w_dstM = RNONE;
   logic [63:0] e_valE = '0, m_valE = '0, m_valM = '0, w_valE = '0, w_valM = '0;
   logic [63:0] rf_valA = 64'd9, rf_valB = 64'd11;
   logic [3:0]  rf_srcA, rf_srcB;
   logic        d_valid, f_stall, e_bubble;
   logic [3:0]  d_icode, d_ifun, d_srcA, d_srcB, d_dstE, d_dstM;
   logic [63:0] d_valC, d_valA, d_valB;

   always #5 clk = ~clk;

   pipe_decode_stage dut (
      .clk(clk), .rst_n(rst_n),
      .f_valid(f_valid), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
      .f_valC(f_valC), .f_valP(f_valP),
      .ext_stall(ext_stall), .e_mispredict(e_mispredict),
      .e_icode(e_icode), .e_dstE(e_dstE), .e_dstM(e_dstM), .e_valE(e_valE),
      .m_dstE(m_dstE), .m_valE(m_valE), .m_dstM(m_dstM), .m_valM(m_valM),
      .w_dstE(w_dstE), .w_valE(w_valE), .w_dstM(w_dstM), .w_valM(w_valM),
      .rf_srcA(rf_srcA), .rf_srcB(rf_srcB), .rf_valA(rf_valA), .rf_valB(rf_valB),
      .d_valid(d_valid), .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC),
      .d_valA(d_valA), .d_valB(d_valB), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .d_dstE(d_dstE), .d_dstM(d_dstM), .f_stall(f_stall), .e_bubble(e_bubble)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the instruction currently held in decode.
   logic        run = 1'b0;
   logic        mv;
   logic [3:0]  mic, mif, mra, mrb;
   logic [63:0] mvc, mvp;

   function automatic logic [3:0] exp_src_a(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'd2, 4'd4, 4'd6, 4'd10}) return ra;
      if (ic inside {4'd9, 4'd11}) return RSP;
      return RNONE;
   endfunction

   function automatic logic [3:0] exp_src_b(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'd4, 4'd5, 4'd6}) return rb;
      if (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) return RSP;
      return RNONE;
   endfunction

   function automatic logic [3:0] exp_dst_e(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'd2, 4'd3, 4'd6}) return rb;
      if (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) return RSP;
      return RNONE;
   endfunction

   function automatic logic [3:0] exp_dst_m(input logic [3:0] ic, input logic [3:0] ra);
      return (ic inside {4'd5, 4'd11}) ? ra : RNONE;
   endfunction

`ifdef PIPE_DECODE_FWD_EN
   function automatic logic [63:0] exp_operand(input logic [3:0] src, input logic [63:0] rf);
      logic [3:0]  ids [5];
      logic [63:0] vals[5];
      ids  = '{e_dstE, m_dstM, m_dstE, w_dstM, w_dstE};
      vals = '{e_valE, m_valM, m_valE, w_valM, w_valE};
      if (src == RNONE) return rf;
      for (int i = 0; i < 5; i++)
         if (ids[i] == src) return vals[i];
      return rf;
   endfunction

   function automatic logic haz_now();
      logic [3:0] sa, sb;
      sa = exp_src_a(mic, mra);
      sb = exp_src_b(mic, mrb);
      if (!mv || !(e_icode inside {4'd5, 4'd11}) || e_dstM == RNONE) return 1'b0;
      return (sa == e_dstM) || (sb == e_dstM);
   endfunction
`else
   function automatic logic [63:0] exp_operand(input logic [3:0] src, input logic [63:0] rf);
      return (src == RNONE) ? rf : rf;
   endfunction

   function automatic logic haz_now();
      logic [3:0] sa, sb;
      logic [3:0] ids[6];
      sa  = exp_src_a(mic, mra);
      sb  = exp_src_b(mic, mrb);
      ids = '{e_dstE, e_dstM, m_dstE, m_dstM, w_dstE, w_dstM};
      if (!mv) return 1'b0;
      for (int i = 0; i < 6; i++)
         if (ids[i] != RNONE && (ids[i] == sa || ids[i] == sb)) return 1'b1;
      return 1'b0;
   endfunction
`endif

   always @(posedge clk) begin
      if (!rst_n || e_mispredict) begin
         mv <= 1'b0; mic <= 4'd1; mif <= 4'd0; mra <= RNONE; mrb <= RNONE;
         mvc <= '0; mvp <= '0;
         if (!rst_n) run <= 1'b1;
      end else if (!(ext_stall || haz_now())) begin
         mv <= f_valid; mic <= f_icode; mif <= f_ifun; mra <= f_rA; mrb <= f_rB;
         mvc <= f_valC; mvp <= f_valP;
      end
   end

   task automatic compare_all();
      logic [3:0]  sa, sb, de, dm;
      logic [63:0] va, vb;
      logic        hz;
      sa = exp_src_a(mic, mra);
      sb = exp_src_b(mic, mrb);
      de = exp_dst_e(mic, mrb);
      dm = exp_dst_m(mic, mra);
      va = (mic inside {4'd7, 4'd8}) ? mvp : exp_operand(sa, rf_valA);
      vb = exp_operand(sb, rf_valB);
      hz = haz_now();
      chk("rf_srcA", 64'(rf_srcA), 64'(sa));
      chk("rf_srcB", 64'(rf_srcB), 64'(sb));
      chk("d_valid", 64'(d_valid), 64'(mv));
      chk("d_icode", 64'(d_icode), mv ? 64'(mic) : 64'd0);
      chk("d_ifun",  64'(d_ifun),  mv ? 64'(mif) : 64'd0);
      chk("d_valC",  d_valC,       mv ? mvc : 64'd0);
      chk("d_valA",  d_valA,       mv ? va : 64'd0);
      chk("d_valB",  d_valB,       mv ? vb : 64'd0);
      chk("d_srcA",  64'(d_srcA),  64'(mv ? sa : RNONE));
      chk("d_srcB",  64'(d_srcB),  64'(mv ? sb : RNONE));
      chk("d_dstE",  64'(d_dstE),  64'(mv ? de : RNONE));
      chk("d_dstM",  64'(d_dstM),  64'(mv ? dm : RNONE));
      chk("f_stall", 64'(f_stall), 64'(ext_stall || hz));
      chk("e_bubble", 64'(e_bubble), 64'(hz || e_mispredict));
   endtask

   always @(negedge clk) if (run) compare_all();

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_fwd();
      e_icode = 4'd1; e_dstE = RNONE; e_dstM = RNONE;
      m_dstE = RNONE; m_dstM = RNONE; w_dstE = RNONE; w_dstM = RNONE;
   endtask

   task automatic fetch(input logic v, input logic [3:0] ic, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp);
      f_valid = v; f_icode = ic; f_ifun = 4'd0; f_rA = ra; f_rB = rb; f_valC = vc; f_valP = vp;
   endtask

   initial begin
      // reset
      tick(); tick();
      rst_n = 1'b1;
      #2;
      chk("rst_valid", 64'(d_valid), 64'd0);
      chk("rst_srcA", 64'(d_srcA), 64'hF);
      chk("rst_srcB", 64'(d_srcB), 64'hF);
      chk("rst_fstall", 64'(f_stall), 64'd0);
      chk("rst_ebubble", 64'(e_bubble), 64'd0);
      chk("rst_valA", d_valA, 64'd0);
      tick();

      // addq %rax,%rbx with %rax produced in E
      fetch(1'b1, 4'd6, 4'd0, 4'd3, 64'd0, 64'h10);
      tick();
      e_dstE = 4'd0; e_valE = 64'd5;
      fetch(1'b0, 4'd1, RNONE, RNONE, 64'd0, 64'd0);
      #2;
`ifdef PIPE_DECODE_FWD_EN
      chk("fwd_valA", d_valA, 64'd5);
      chk("fwd_fstall", 64'(f_stall), 64'd0);
`else
      chk("nofwd_valA", d_valA, 64'd9);
      chk("nofwd_fstall", 64'(f_stall), 64'd1);
`endif
      chk("fwd_srcB", 64'(d_srcB), 64'd3);
      chk("fwd_dstE", 64'(d_dstE), 64'd3);
      tick();

      // rrmovq %rdx,%rbp: E result must beat M load result
      clr_fwd();
      fetch(1'b1, 4'd2, 4'd2, 4'd5, 64'd0, 64'h12);
      tick();
      e_dstE = 4'd2; e_valE = 64'd7; m_dstM = 4'd2; m_valM = 64'd8;
      fetch(1'b0, 4'd1, RNONE, RNONE, 64'd0, 64'd0);
      #2;
`ifdef PIPE_DECODE_FWD_EN
      chk("prio_valA", d_valA, 64'd7);
`else
      chk("prio_valA", d_valA, 64'd9);
      chk("prio_fstall", 64'(f_stall), 64'd1);
`endif
      chk("prio_dstE", 64'(d_dstE), 64'd5);
      tick();

      // mrmovq -> %rcx in E, addq %rcx,%rdx in D
      clr_fwd();
      fetch(1'b1, 4'd6, 4'd1, 4'd2, 64'd0, 64'h20);
      tick();
      e_icode = 4'd5; e_dstM = 4'd1;
      fetch(1'b1, 4'd3, RNONE, 4'd6, 64'h55, 64'h2a);
      #2;
      chk("lu_fstall", 64'(f_stall), 64'd1);
      chk("lu_ebubble", 64'(e_bubble), 64'd1);
      chk("lu_icode", 64'(d_icode), 64'd6);
      tick();
      e_icode = 4'd1; e_dstM = RNONE; m_dstM = 4'd1; m_valM = 64'h77;
      #2;
      chk("lu2_icode", 64'(d_icode), 64'd6);
`ifdef PIPE_DECODE_FWD_EN
      chk("lu2_valA", d_valA, 64'h77);
      chk("lu2_fstall", 64'(f_stall), 64'd0);
      chk("lu2_ebubble", 64'(e_bubble), 64'd0);
`else
      chk("lu2_valA", d_valA, 64'd9);
      chk("lu2_fstall", 64'(f_stall), 64'd1);
`endif
      tick();
      clr_fwd();
      tick();
      #2;
      chk("irmov_icode", 64'(d_icode), 64'd3);
      chk("irmov_valC", d_valC, 64'h55);
      chk("irmov_dstE", 64'(d_dstE), 64'd6);
      tick();

      // mispredict flushes the fetched instruction
      e_mispredict = 1'b1;
      fetch(1'b1, 4'd6, 4'd0, 4'd1, 64'd0, 64'h30);
      #2;
      chk("mp_ebubble", 64'(e_bubble), 64'd1);
      tick();
      e_mispredict = 1'b0;
      fetch(1'b0, 4'd1, RNONE, RNONE, 64'd0, 64'd0);
      #2;
      chk("mp_valid", 64'(d_valid), 64'd0);
      tick();
      #2;
      chk("mp_gone", 64'(d_valid), 64'd0);

      // mispredict coincident with a load-use stall
      fetch(1'b1, 4'd6, 4'd1, 4'd2, 64'd0, 64'h40);
      tick();
      e_icode = 4'd5; e_dstM = 4'd1; e_mispredict = 1'b1;
      fetch(1'b1, 4'd3, RNONE, 4'd6, 64'h66, 64'h4a);
      #2;
      chk("mplu_ebubble", 64'(e_bubble), 64'd1);
      tick();
      clr_fwd(); e_mispredict = 1'b0;
      fetch(1'b0, 4'd1, RNONE, RNONE, 64'd0, 64'd0);
      #2;
      chk("mplu_valid", 64'(d_valid), 64'd0);
      tick();

      // call then popq %rbx
      rf_valB = 64'h1000;
      fetch(1'b1, 4'd8, RNONE, RNONE, 64'h100, 64'h209);
      tick();
      fetch(1'b1, 4'd11, 4'd3, RNONE, 64'd0, 64'h20b);
      #2;
      chk("call_valA", d_valA, 64'h209);
      chk("call_srcA", 64'(d_srcA), 64'hF);
      chk("call_srcB", 64'(d_srcB), 64'd4);
      chk("call_dstE", 64'(d_dstE), 64'd4);
      chk("call_valB", d_valB, 64'h1000);
      tick();
      fetch(1'b1, 4'd3, RNONE, 4'd7, 64'hAA, 64'h215);
      #2;
      chk("pop_srcA", 64'(d_srcA), 64'd4);
      chk("pop_srcB", 64'(d_srcB), 64'd4);
      chk("pop_dstE", 64'(d_dstE), 64'd4);
      chk("pop_dstM", 64'(d_dstM), 64'd3);
      tick();

      // external stall holds D without a bubble, then reset discards it
      ext_stall = 1'b1;
      fetch(1'b1, 4'd1, RNONE, RNONE, 64'd0, 64'h216);
      #2;
      chk("xs_fstall", 64'(f_stall), 64'd1);
      chk("xs_ebubble", 64'(e_bubble), 64'd0);
      tick();
      #2;
      chk("xs_icode", 64'(d_icode), 64'd3);
      chk("xs_valC", d_valC, 64'hAA);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; ext_stall = 1'b0;
      fetch(1'b0, 4'd1, RNONE, RNONE, 64'd0, 64'd0);
      #2;
      chk("rs_valid", 64'(d_valid), 64'd0);
      chk("rs_srcA", 64'(d_srcA), 64'hF);
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_decode_stage.md
# pipe_decode_stage

Parametrised decode stage for the pipelined Y86-64 core, successor to the single-cycle SEQ decode logic. It owns the F→D pipeline register, generates srcA/srcB/dstE/dstM, drives the register-file read ports, and selects operands from the register file or the E/M/W forwarding paths. It also detects load-use hazards and produces the stall/bubble controls for fetch and execute. It sits between the fetch stage and the E pipeline register.

## Interface
- DATA_W, 64: operand/constant width.
- RID_W, 4: register-ID width; all-ones (4'hF) = RNONE.
- RSP_ID, 4: register ID of %rsp.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- f_valid, f_icode[4], f_ifun[4], f_rA[RID_W], f_rB[RID_W], f_valC[DATA_W], f_valP[DATA_W]  in  fetched instruction.
- ext_stall  in  1  downstream hold; freezes the D register.
- e_mispredict  in  1  branch mispredict in E; flushes the D register.
- e_icode[4], e_dstE, e_dstM, e_valE  in  E-stage forwarding/hazard info.
- m_dstE, m_valE, m_dstM, m_valM  in  M-stage forwarding.
- w_dstE, w_valE, w_dstM, w_valM  in  W-stage forwarding.
- rf_srcA, rf_srcB  out  RID_W  register-file read addresses.
- rf_valA, rf_valB  in  DATA_W  register-file read data (combinational).
- d_valid, d_icode, d_ifun, d_valC, d_valA, d_valB, d_srcA, d_srcB, d_dstE, d_dstM  out  decoded instruction to the E register.
- f_stall  out  1  hold fetch PC/instruction.
- e_bubble  out  1  insert a bubble into the E register.

## Operation
- D register: {valid, icode, ifun, rA, rB, valC, valP}. Priority order: reset > e_mispredict (load bubble: valid=0, icode=1, rA=rB=RNONE) > hold (ext_stall or load-use) > load from f_*.
- srcA: icode ∈ {2,4,6,10} → rA; {9,11} → RSP_ID; otherwise RNONE.
- srcB: icode ∈ {4,5,6} → rB; {8,9,10,11} → RSP_ID; otherwise RNONE.
- dstE: icode ∈ {2,3,6} → rB; {8,9,10,11} → RSP_ID; otherwise RNONE. cmov condition is resolved in E, not here.
- dstM: icode ∈ {5,11} → rA; otherwise RNONE.
- rf_srcA/rf_srcB = srcA/srcB, combinational from the D register.
- valA: icode ∈ {7,8} → valP; otherwise the forwarded srcA value. valB: the forwarded srcB value.
- Forward priority per operand, first match wins: e_dstE/e_valE, m_dstM/m_valM, m_dstE/m_valE, w_dstM/w_valM, w_dstE/w_valE, then the register file. RNONE never matches.
- Load-use: e_icode ∈ {5,11}, and e_dstM ≠ RNONE equals a non-RNONE srcA or srcB, and D is valid.
  - Result: f_stall=1, e_bubble=1, D holds.
  - With no load-use: e_bubble = e_mispredict.
- All d_* outputs are zero-extended/RNONE when d_valid=0. Downstream ignores them.

## Timing
- Decode and forwarding are combinational from the D register; D→E latency is one cycle.
- Reset (rst_n=0 at the edge):
  - D register: valid=0, icode=1, ifun=0, rA=rB=RNONE, valC=valP=0.
  - Outputs: d_valid=0, all IDs=RNONE, all values=0, f_stall=0, e_bubble=0.
- Reset mid-stall discards the held instruction.
- e_mispredict together with a load-use condition: the flush wins, and the D register becomes a bubble on the next edge.
- ext_stall holds D and asserts f_stall. It does not assert e_bubble unless load-use is also present.
- A load-use stall lasts exactly one cycle. The next cycle forwards m_valM.

## Configuration
- PIPE_DECODE_FWD_EN defined: forwarding network as described above; only load-use stalls.
- Undefined:
  - No forwarding; valA/valB come from rf_valA/rf_valB only.
  - Any non-RNONE src matching e_dstE, e_dstM, m_dstE, m_dstM, w_dstE or w_dstM raises f_stall=1 and e_bubble=1. D holds until the match clears.

## Test plan
- Reset: hold rst_n=0 for 2 cycles, then release with f_valid=0. Expect d_valid=0, d_srcA=d_srcB=4'hF, f_stall=0, e_bubble=0.
- Forwarding: decode addq (icode 6) %rax→%rbx with e_dstE=0, e_valE=5, rf_valA=9. Expect d_valA=5, d_srcB=3, d_dstE=3.
- Priority: with both e_dstE=2 (e_valE=7) and m_dstM=2 (m_valM=8), decoding rrmovq rA=2 gives d_valA=7.
- Load-use: mrmovq→%rcx in E (e_icode=5, e_dstM=1), then addq %rcx,%rdx in D. Expect one cycle of f_stall=e_bubble=1, then d_valA=m_valM.
- Mispredict: assert e_mispredict with a valid F instruction. The next cycle gives d_valid=0, and the instruction is not re-presented.
- Call/push: call (icode 8) gives d_valA=valP, d_srcB=4, d_dstE=4. popq gives d_srcA=d_srcB=4, d_dstE=4, d_dstM=rA.
